// File: rtl/mac_tx_pkg.sv
// Shared definitions for the transmit enqueue path: class codes, PTP header offsets,
// descriptor layout and the enqueue FSM encoding.
package mac_tx_pkg;

    localparam logic [3:0] CLS_SYNC   = 4'h4;
    localparam logic [3:0] CLS_FOLLOW = 4'h8;
    localparam logic [3:0] CLS_REQ    = 4'h0;
    localparam logic [3:0] CLS_NORMAL = 4'h1;

    localparam logic [15:0] ETYPE_IPV4       = 16'h0800;
    localparam logic [15:0] ETYPE_PTP        = 16'h88F7;
    localparam logic [15:0] PTP_PORT_EVENT   = 16'd319;
    localparam logic [15:0] PTP_PORT_GENERAL = 16'd320;
    localparam logic [7:0]  IPV4_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP     = 8'h11;

    // Byte 14 is both the L2 PTP messageType and the IPv4 version/IHL byte.
    localparam logic [5:0] OFF_ETYPE_HI = 6'd12;
    localparam logic [5:0] OFF_ETYPE_LO = 6'd13;
    localparam logic [5:0] OFF_BYTE14   = 6'd14;
    localparam logic [5:0] OFF_IP_PROTO = 6'd23;
    localparam logic [5:0] OFF_DPORT_HI = 6'd36;
    localparam logic [5:0] OFF_DPORT_LO = 6'd37;
    localparam logic [5:0] OFF_UDP_MSG  = 6'd42;
    localparam logic [5:0] OFF_MAX      = 6'd63;

    typedef struct packed {
        logic [3:0]  cls;
        logic        rsvd;
        logic [10:0] len;
    } desc_t;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StPad,
        StDiscard,
        StPtr
    } state_e;

    function automatic logic [3:0] ptp_class(input logic [3:0] msg_type);
        case (msg_type)
            4'h0:    return CLS_SYNC;
            4'h1:    return CLS_REQ;
            4'h8:    return CLS_FOLLOW;
            default: return CLS_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/mac_t_frame_enq_if.sv
// Byte stream and FIFO write-side signals of the transmit enqueue stage.
interface mac_t_frame_enq_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic        in_eof;
    logic [7:0]  in_data;
    logic        data_fifo_wr;
    logic [7:0]  data_fifo_din;
    logic [11:0] data_fifo_depth;
    logic        ptr_fifo_wr;
    logic [15:0] ptr_fifo_din;
    logic        ptr_fifo_full;

    modport master (
        output in_valid, in_sof, in_eof, in_data, data_fifo_depth, ptr_fifo_full,
        input  in_ready, data_fifo_wr, data_fifo_din, ptr_fifo_wr, ptr_fifo_din
    );

    modport slave (
        input  in_valid, in_sof, in_eof, in_data, data_fifo_depth, ptr_fifo_full,
        output in_ready, data_fifo_wr, data_fifo_din, ptr_fifo_wr, ptr_fifo_din
    );
endinterface

// File: rtl/mac_t_ptp_classify.sv
// Classifies a frame as PTP sync/follow_up/delay_req (UDPv4 or raw L2) from its received bytes.
// The class register is reset at sof and is valid the cycle after the last byte.
module mac_t_ptp_classify
    import mac_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       byte_valid,
    input  logic       byte_sof,
    input  logic [5:0] byte_off,
    input  logic [7:0] byte_data,
    output logic [3:0] cls
);

    logic [7:0] hold_q, hold_d;
    logic       is_ip_q, is_ip_d, is_l2_q, is_l2_d;
    logic       ip_hdr_q, ip_hdr_d, udp_q, udp_d, port_q, port_d;
    logic [3:0] cls_q, cls_d;

    always_comb begin
        hold_d   = hold_q;
        is_ip_d  = is_ip_q;
        is_l2_d  = is_l2_q;
        ip_hdr_d = ip_hdr_q;
        udp_d    = udp_q;
        port_d   = port_q;
        cls_d    = cls_q;
        if (byte_valid) begin
            if (byte_sof) begin
                is_ip_d  = 1'b0;
                is_l2_d  = 1'b0;
                ip_hdr_d = 1'b0;
                udp_d    = 1'b0;
                port_d   = 1'b0;
                cls_d    = CLS_NORMAL;
            end
            case (byte_off)
                OFF_ETYPE_HI, OFF_DPORT_HI: hold_d = byte_data;
                OFF_ETYPE_LO: begin
                    is_ip_d = ({hold_q, byte_data} == ETYPE_IPV4);
                    is_l2_d = ({hold_q, byte_data} == ETYPE_PTP);
                end
                OFF_BYTE14: begin
                    ip_hdr_d = (byte_data == IPV4_VER_IHL);
                    if (is_l2_q) cls_d = ptp_class(byte_data[3:0]);
                end
                OFF_IP_PROTO: udp_d = (byte_data == IP_PROTO_UDP);
                OFF_DPORT_LO: port_d = ({hold_q, byte_data} == PTP_PORT_EVENT) ||
                                       ({hold_q, byte_data} == PTP_PORT_GENERAL);
                OFF_UDP_MSG: begin
                    if (is_ip_q && ip_hdr_q && udp_q && port_q) cls_d = ptp_class(byte_data[3:0]);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_q   <= 8'h00;
            is_ip_q  <= 1'b0;
            is_l2_q  <= 1'b0;
            ip_hdr_q <= 1'b0;
            udp_q    <= 1'b0;
            port_q   <= 1'b0;
            cls_q    <= 4'h0;
        end else begin
            hold_q   <= hold_d;
            is_ip_q  <= is_ip_d;
            is_l2_q  <= is_l2_d;
            ip_hdr_q <= ip_hdr_d;
            udp_q    <= udp_d;
            port_q   <= port_d;
            cls_q    <= cls_d;
        end
    end

    assign cls = cls_q;

endmodule

// File: rtl/mac_t_frame_enq.sv
// Transmit enqueue stage: writes frame bytes to the data FIFO, pads runts, truncates oversize
// frames and appends one {class, 0, len} descriptor per frame to the pointer FIFO.
module mac_t_frame_enq
    import mac_tx_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 1514,
    parameter int unsigned MIN_LEN   = 60,
    parameter int unsigned DEPTH_THR = 2578
) (
    input  logic              sys_clk,
    input  logic              rstn_sys,
    mac_t_frame_enq_if.slave  bus,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       ptp_cnt,
    output logic [15:0]       err_cnt
);

    localparam logic [10:0] MaxLen   = 11'(MAX_LEN);
    localparam logic [10:0] MinLen   = 11'(MIN_LEN);
    localparam logic [11:0] DepthThr = 12'(DEPTH_THR);

    state_e      state_q, state_d;
    logic [10:0] len_q, len_d, len_new;
    logic [5:0]  off_q, off_d, cls_off;
    logic        in_ready_q, in_ready_d;
    logic        wr_q, wr_d, ptr_wr_q, ptr_wr_d;
    logic [7:0]  din_q, din_d;
    desc_t       ptr_din_q, ptr_din_d;
    logic [15:0] frame_cnt_q, ptp_cnt_q, err_cnt_q;
    logic [1:0]  err_inc;
    logic        frame_inc, ptp_inc, cls_byte, cls_sof, byte_ok;
    logic [3:0]  cls;

    assign byte_ok = bus.in_valid & in_ready_q;

    mac_t_ptp_classify u_classify (
        .clk        (sys_clk),
        .rstn       (rstn_sys),
        .byte_valid (cls_byte),
        .byte_sof   (cls_sof),
        .byte_off   (cls_off),
        .byte_data  (bus.in_data),
        .cls        (cls)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        off_d     = off_q;
        len_new   = len_q + 11'd1;
        wr_d      = 1'b0;
        din_d     = 8'h00;
        ptr_wr_d  = 1'b0;
        ptr_din_d = '0;
        err_inc   = 2'd0;
        frame_inc = 1'b0;
        ptp_inc   = 1'b0;
        cls_byte  = 1'b0;
        cls_sof   = 1'b0;
        cls_off   = off_q;
        unique case (state_q)
            StIdle, StData: begin
                if (byte_ok) begin
                    if (state_q == StIdle && !bus.in_sof) begin
                        err_inc = 2'd1;
                    end else begin
                        if (state_q == StIdle) begin
                            len_new = 11'd1;
                            cls_sof = 1'b1;
                            cls_off = 6'd0;
                        end else if (bus.in_sof) begin
                            err_inc = 2'd1;
                        end
                        cls_byte = 1'b1;
                        wr_d     = 1'b1;
                        din_d    = bus.in_data;
                        len_d    = len_new;
                        off_d    = (cls_off == OFF_MAX) ? OFF_MAX : cls_off + 6'd1;
                        if (bus.in_eof) begin
                            state_d = (len_new < MinLen) ? StPad : StPtr;
                        end else if (len_new == MaxLen) begin
                            state_d = StDiscard;
                            err_inc = err_inc + 2'd1;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StPad: begin
                wr_d  = 1'b1;
                len_d = len_new;
                if (len_new >= MinLen) state_d = StPtr;
            end
            StDiscard: begin
                if (byte_ok && bus.in_eof) state_d = StPtr;
            end
            StPtr: begin
                ptr_wr_d  = 1'b1;
                ptr_din_d = '{cls: cls, rsvd: 1'b0, len: len_q};
                frame_inc = 1'b1;
                ptp_inc   = (cls != CLS_NORMAL);
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Admission is decided from FIFO status only while waiting for a sof.
    always_comb begin
        unique case (state_d)
            StIdle:            in_ready_d = !bus.ptr_fifo_full && (bus.data_fifo_depth <= DepthThr);
            StData, StDiscard: in_ready_d = 1'b1;
            default:           in_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn_sys) begin
            state_q     <= StIdle;
            len_q       <= 11'd0;
            off_q       <= 6'd0;
            in_ready_q  <= 1'b0;
            wr_q        <= 1'b0;
            din_q       <= 8'h00;
            ptr_wr_q    <= 1'b0;
            ptr_din_q   <= '0;
            frame_cnt_q <= 16'd0;
            ptp_cnt_q   <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            off_q       <= off_d;
            in_ready_q  <= in_ready_d;
            wr_q        <= wr_d;
            din_q       <= din_d;
            ptr_wr_q    <= ptr_wr_d;
            ptr_din_q   <= ptr_din_d;
            frame_cnt_q <= frame_cnt_q + {15'd0, frame_inc};
            ptp_cnt_q   <= ptp_cnt_q + {15'd0, ptp_inc};
            err_cnt_q   <= err_cnt_q + {14'd0, err_inc};
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.data_fifo_wr  = wr_q;
    assign bus.data_fifo_din = din_q;
    assign bus.ptr_fifo_wr   = ptr_wr_q;
    assign bus.ptr_fifo_din  = ptr_din_q;
    assign frame_cnt         = frame_cnt_q;
    assign ptp_cnt           = ptp_cnt_q;
    assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_mac_t_frame_enq.sv
// Self-checking bench for mac_t_frame_enq: random frames against a frame-level reference model.
module tb_mac_t_frame_enq;

    logic        sys_clk = 1'b0;
    logic        rstn_sys = 1'b0;
    logic [15:0] frame_cnt, ptp_cnt, err_cnt;

    mac_t_frame_enq_if bus ();

    mac_t_frame_enq dut (
        .sys_clk   (sys_clk),
        .rstn_sys  (rstn_sys),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .ptp_cnt   (ptp_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned hs_cyc = 0;
    logic [7:0]  frame_q[$];
    logic [7:0]  wr_q[$];
    logic [15:0] ptr_q[$];
    int          ptr_at_q[$];
    logic [15:0] exp_frame = 16'd0, exp_ptp = 16'd0, exp_err = 16'd0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Data-write count is recorded before this cycle's data write, so a descriptor that
    // overtook its last byte shows up as a short count.
    always @(negedge sys_clk) begin
        if (bus.ptr_fifo_wr) begin
            ptr_q.push_back(bus.ptr_fifo_din);
            ptr_at_q.push_back(wr_q.size());
        end
        if (bus.data_fifo_wr) wr_q.push_back(bus.data_fifo_din);
    end

    function automatic logic [3:0] model_class();
        int n = frame_q.size();
        logic [7:0] mt;
        if (n > 14 && frame_q[12] == 8'h88 && frame_q[13] == 8'hF7) mt = frame_q[14];
        else if (n > 42 && frame_q[12] == 8'h08 && frame_q[13] == 8'h00 && frame_q[14] == 8'h45 &&
                 frame_q[23] == 8'h11 && frame_q[36] == 8'h01 &&
                 (frame_q[37] == 8'h3F || frame_q[37] == 8'h40)) mt = frame_q[42];
        else return 4'h1;
        case (mt[3:0])
            4'h0:    return 4'h4;
            4'h8:    return 4'h8;
            4'h1:    return 4'h0;
            default: return 4'h1;
        endcase
    endfunction

    function automatic int model_len(input int n);
        return (n > 1514) ? 1514 : ((n < 60) ? 60 : n);
    endfunction

    // kind 0 = plain, 1 = UDPv4 PTP header, 2 = L2 PTP header
    task automatic build(input int kind, input int len, input logic [7:0] mt_byte,
                         input logic [15:0] port);
        frame_q.delete();
        for (int i = 0; i < ((len > 64) ? len : 64); i++) frame_q.push_back(8'($urandom));
        frame_q[12] = 8'h00;
        if (kind == 1) begin
            frame_q[12] = 8'h08; frame_q[13] = 8'h00; frame_q[14] = 8'h45; frame_q[23] = 8'h11;
            frame_q[36] = port[15:8]; frame_q[37] = port[7:0]; frame_q[42] = mt_byte;
        end else if (kind == 2) begin
            frame_q[12] = 8'h88; frame_q[13] = 8'hF7; frame_q[14] = mt_byte;
        end
        while (frame_q.size() > len) void'(frame_q.pop_back());
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic s, input logic e, output bit ok);
        int guard = 0;
        bus.in_valid = 1'b1; bus.in_sof = s; bus.in_eof = e; bus.in_data = d;
        while (bus.in_ready !== 1'b1 && guard < 2000) begin
            @(negedge sys_clk);
            guard++;
        end
        ok = (bus.in_ready === 1'b1);
        if (ok) begin
            @(negedge sys_clk);
            hs_cyc = cyc;
        end
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
    endtask

    task automatic send_frame(input string name, input int gap_pct, input int sof_at);
        bit ok = 1'b1;
        for (int i = 0; i < frame_q.size() && ok; i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) @(negedge sys_clk);
            drive_byte(frame_q[i], (i == 0) || (i == sof_at), i == frame_q.size() - 1, ok);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s accept: in_ready stuck low, got 0 want 1", name);
        end
    endtask

    task automatic check_frame(input string name, output logic [15:0] got_desc);
        int n = frame_q.size();
        int elen = model_len(n);
        logic [3:0] ecls = model_class();
        logic [15:0] edesc = {ecls, 1'b0, 11'(elen)};
        int guard = 0;
        int bad_at = -1;
        got_desc = 16'hxxxx;
        while (ptr_q.size() == 0 && guard < 300) begin
            @(negedge sys_clk);
            guard++;
        end
        repeat (3) @(negedge sys_clk);
        exp_frame++;
        if (ecls != 4'h1) exp_ptp++;
        if (n > 1514) exp_err++;
        n_cmp++;
        if (ptr_q.size() != 1) begin
            n_bad++;
            $display("FAIL %s desc_count: got %0d want 1", name, ptr_q.size());
        end else begin
            got_desc = ptr_q[0];
            n_cmp++;
            if (ptr_q[0] !== edesc) begin
                n_bad++;
                $display("FAIL %s desc: got %h want %h", name, ptr_q[0], edesc);
            end
            n_cmp++;
            if (ptr_at_q[0] != elen) begin
                n_bad++;
                $display("FAIL %s desc_order: writes before desc got %0d want %0d",
                         name, ptr_at_q[0], elen);
            end
        end
        n_cmp++;
        if (wr_q.size() != elen) begin
            n_bad++;
            $display("FAIL %s wr_count: got %0d want %0d", name, wr_q.size(), elen);
        end
        for (int i = 0; i < elen && i < wr_q.size(); i++) begin
            if (bad_at < 0 && wr_q[i] !== ((i < n) ? frame_q[i] : 8'h00)) bad_at = i;
        end
        n_cmp++;
        if (bad_at >= 0) begin
            n_bad++;
            $display("FAIL %s data[%0d]: got %h want %h", name, bad_at, wr_q[bad_at],
                     (bad_at < n) ? frame_q[bad_at] : 8'h00);
        end
        n_cmp++;
        if ({frame_cnt, ptp_cnt, err_cnt} !== {exp_frame, exp_ptp, exp_err}) begin
            n_bad++;
            $display("FAIL %s counters: got %h/%h/%h want %h/%h/%h", name, frame_cnt, ptp_cnt,
                     err_cnt, exp_frame, exp_ptp, exp_err);
        end
        wr_q.delete(); ptr_q.delete(); ptr_at_q.delete();
    endtask

    task automatic check_zero_outputs(input string name);
        n_cmp++;
        if ({bus.in_ready, bus.data_fifo_wr, bus.data_fifo_din, bus.ptr_fifo_wr, bus.ptr_fifo_din,
             frame_cnt, ptp_cnt, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL %s outputs: got rdy=%b wr=%b din=%h pwr=%b pdin=%h cnt=%h/%h/%h want 0",
                     name, bus.in_ready, bus.data_fifo_wr, bus.data_fifo_din, bus.ptr_fifo_wr,
                     bus.ptr_fifo_din, frame_cnt, ptp_cnt, err_cnt);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        check_zero_outputs("reset");
        rstn_sys = 1'b1;
        repeat (2) @(negedge sys_clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_random_frame();
        logic [15:0] d;
        build(0, 100, 8'h00, 16'h0);
        send_frame("rand100", 0, -1);
        check_frame("rand100", d);
        n_cmp++;
        if (d !== 16'h1064 || frame_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL rand100_const: got %h cnt %0d want 1064 cnt 1", d, frame_cnt);
        end
    endtask

    task automatic test_ptp();
        logic [15:0] d;
        logic [7:0]  mts[3] = '{8'h00, 8'h08, 8'h01};
        logic [15:0] want[3] = '{16'h4056, 16'h8056, 16'h0056};
        for (int k = 0; k < 3; k++) begin
            build(1, 86, mts[k], 16'd319);
            send_frame("udp_ptp", 0, -1);
            check_frame("udp_ptp", d);
            n_cmp++;
            if (d !== want[k]) begin
                n_bad++;
                $display("FAIL udp_ptp_const: got %h want %h", d, want[k]);
            end
        end
        build(2, 70, 8'h10, 16'h0);
        send_frame("l2_sync", 0, -1);
        check_frame("l2_sync", d);
        build(1, 90, 8'h09, 16'd320);
        send_frame("delay_resp", 0, -1);
        check_frame("delay_resp", d);
    endtask

    task automatic test_pad();
        logic [15:0] d;
        int guard = 0;
        int rdy_hi = 0;
        build(0, 40, 8'h00, 16'h0);
        send_frame("pad40", 0, -1);
        while (bus.ptr_fifo_wr !== 1'b1 && guard < 100) begin
            if (bus.in_ready !== 1'b0) rdy_hi++;
            @(negedge sys_clk);
            guard++;
        end
        n_cmp++;
        if (rdy_hi != 0) begin
            n_bad++;
            $display("FAIL pad_ready: got %0d ready cycles want 0", rdy_hi);
        end
        check_frame("pad40", d);
        n_cmp++;
        if (d !== 16'h103C) begin
            n_bad++;
            $display("FAIL pad_const: got %h want 103c", d);
        end
    endtask

    task automatic test_oversize();
        logic [15:0] d;
        build(0, 1600, 8'h00, 16'h0);
        send_frame("big1600", 0, -1);
        check_frame("big1600", d);
        n_cmp++;
        if (d !== 16'h15EA) begin
            n_bad++;
            $display("FAIL big_const: got %h want 15ea", d);
        end
    endtask

    task automatic test_admission();
        logic [15:0] d;
        int rdy_hi;
        for (int k = 0; k < 2; k++) begin
            build(0, 70, 8'h00, 16'h0);
            if (k == 0) bus.data_fifo_depth = 12'd2579;
            else bus.ptr_fifo_full = 1'b1;
            repeat (2) @(negedge sys_clk);
            bus.in_valid = 1'b1; bus.in_sof = 1'b1; bus.in_eof = 1'b0; bus.in_data = frame_q[0];
            rdy_hi = 0;
            repeat (10) begin
                if (bus.in_ready !== 1'b0) rdy_hi++;
                @(negedge sys_clk);
            end
            n_cmp++;
            if (rdy_hi != 0 || wr_q.size() != 0) begin
                n_bad++;
                $display("FAIL admit_block%0d: got %0d ready/%0d writes want 0/0", k, rdy_hi,
                         wr_q.size());
            end
            bus.data_fifo_depth = 12'd2578;
            bus.ptr_fifo_full = 1'b0;
            send_frame("admit_release", 0, -1);
            check_frame("admit_release", d);
        end
        bus.data_fifo_depth = 12'd0;
    endtask

    task automatic test_framing();
        logic [15:0] d;
        bit ok;
        drive_byte(8'hA5, 1'b0, 1'b1, ok);
        repeat (2) @(negedge sys_clk);
        exp_err++;
        n_cmp++;
        if (!ok || wr_q.size() != 0 || err_cnt !== exp_err) begin
            n_bad++;
            $display("FAIL stray_byte: got ok=%b wr=%0d err=%0d want 1/0/%0d", ok, wr_q.size(),
                     err_cnt, exp_err);
        end
        build(0, 80, 8'h00, 16'h0);
        send_frame("mid_sof", 0, 30);
        exp_err++;
        check_frame("mid_sof", d);
    endtask

    task automatic test_back_to_back();
        logic [15:0] da, db;
        int la, lb;
        int unsigned eof_cyc;
        int guard = 0;
        la = 60 + $urandom_range(20);
        lb = 60 + $urandom_range(20);
        build(0, la, 8'h00, 16'h0);
        send_frame("b2b_a", 0, -1);
        eof_cyc = hs_cyc;
        build(0, lb, 8'h00, 16'h0);
        send_frame("b2b_b", 0, -1);
        n_cmp++;
        if (hs_cyc - eof_cyc != unsigned'(lb + 1)) begin
            n_bad++;
            $display("FAIL b2b_gap: got %0d cycles want %0d", hs_cyc - eof_cyc, lb + 1);
        end
        while (ptr_q.size() < 2 && guard < 100) begin
            @(negedge sys_clk);
            guard++;
        end
        repeat (2) @(negedge sys_clk);
        da = {4'h1, 1'b0, 11'(la)};
        db = {4'h1, 1'b0, 11'(lb)};
        exp_frame += 16'd2;
        n_cmp++;
        if (ptr_q.size() != 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want 2", ptr_q.size());
        end else begin
            n_cmp++;
            if (ptr_q[0] !== da || ptr_q[1] !== db || ptr_at_q[1] != la + lb) begin
                n_bad++;
                $display("FAIL b2b_desc: got %h %h @%0d want %h %h @%0d", ptr_q[0], ptr_q[1],
                         ptr_at_q[1], da, db, la + lb);
            end
        end
        n_cmp++;
        if (frame_cnt !== exp_frame) begin
            n_bad++;
            $display("FAIL b2b_frame_cnt: got %0d want %0d", frame_cnt, exp_frame);
        end
        wr_q.delete(); ptr_q.delete(); ptr_at_q.delete();
    endtask

    task automatic test_random_mix();
        logic [15:0] d;
        logic [3:0]  mt_lo[5] = '{4'h0, 4'h1, 4'h8, 4'h9, 4'h2};
        logic [15:0] ports[3] = '{16'd319, 16'd320, 16'd321};
        for (int k = 0; k < 12; k++) begin
            build(int'($urandom_range(2)), int'($urandom_range(1, 130)),
                  {4'($urandom), mt_lo[$urandom_range(4)]}, ports[$urandom_range(2)]);
            send_frame("mix", 20, -1);
            check_frame("mix", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        bit ok = 1'b1;
        build(0, 40, 8'h00, 16'h0);
        for (int i = 0; i < 30 && ok; i++) drive_byte(frame_q[i], i == 0, 1'b0, ok);
        rstn_sys = 1'b0;
        repeat (2) @(negedge sys_clk);
        check_zero_outputs("reset_mid");
        rstn_sys = 1'b1;
        wr_q.delete(); ptr_q.delete(); ptr_at_q.delete();
        exp_frame = 16'd0; exp_ptp = 16'd0; exp_err = 16'd0;
        repeat (4) @(negedge sys_clk);
        n_cmp++;
        if (ptr_q.size() != 0 || wr_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_mid_abandon: got %0d desc %0d writes want 0/0", ptr_q.size(),
                     wr_q.size());
        end
        build(0, 70, 8'h00, 16'h0);
        send_frame("after_reset", 0, -1);
        check_frame("after_reset", d);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0; bus.in_data = 8'h00;
        bus.data_fifo_depth = 12'd0;
        bus.ptr_fifo_full = 1'b0;
        test_reset();
        test_random_frame();
        test_ptp();
        test_pad();
        test_oversize();
        test_admission();
        test_framing();
        test_back_to_back();
        test_random_mix();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_t_frame_enq.md
Name: mac_t_frame_enq

Overview:
Transmit-side enqueue stage sitting directly upstream of the GMII transmit MAC. It accepts frames from the switch egress byte stream on sys_clk and writes them into the per-port data FIFO. After each frame it writes one descriptor into the pointer FIFO: {class[3:0], 1'b0, len[10:0]}. It classifies PTP (UDPv4 and raw L2) messages so the MAC can timestamp them, pads runts to 60 bytes and truncates oversize frames.

Parameters:
MAX_LEN, 1514, largest frame length written (bytes, excluding FCS)
MIN_LEN, 60, runt frames are zero-padded to this length
DEPTH_THR, 2578, a frame is admitted only if data_fifo_depth <= DEPTH_THR

Ports:
sys_clk  in  1  system clock
rstn_sys  in  1  synchronous active-low reset
in_valid  in  1  input byte valid
in_ready  out  1  input byte accepted when in_valid & in_ready
in_sof  in  1  first byte of frame
in_eof  in  1  last byte of frame
in_data  in  8  frame byte
data_fifo_wr  out  1  data FIFO write enable
data_fifo_din  out  8  data FIFO write data
data_fifo_depth  in  12  data FIFO write-side fill count
ptr_fifo_wr  out  1  pointer FIFO write enable
ptr_fifo_din  out  16  descriptor {class, 1'b0, len}
ptr_fifo_full  in  1  pointer FIFO full
frame_cnt  out  16  frames enqueued (wraps)
ptp_cnt  out  16  frames classified sync/follow_up/delay_req (wraps)
err_cnt  out  16  truncations plus framing errors (wraps)

Behaviour:
- Interface: one clock (sys_clk); reset rstn_sys is synchronous, active-low. All outputs are registered.
- Reset: every output is 0, state is IDLE, and length/class registers are cleared. Reset asserted mid-frame abandons the frame and writes no descriptor.
- Class codes: 4'h4 = PTP sync; 4'h8 = PTP follow_up; 4'h0 = PTP delay_req; 4'h1 = everything else, including delay_resp.
- PTP detection:
  - UDPv4 form: bytes 12-13 = 0x0800, byte 14 = 0x45, byte 23 = 0x11, bytes 36-37 = 0x013F or 0x0140; messageType = byte 42 [3:0].
  - L2 form: bytes 12-13 = 0x88F7; messageType = byte 14 [3:0].
  - messageType 0 -> sync, 1 -> delay_req, 8 -> follow_up.
  - Only received bytes are examined, never pad bytes. A frame ending before the messageType byte is class 1.
- FSM states: IDLE, DATA, PAD, DISCARD, PTR.
- IDLE:
  - in_ready = !ptr_fifo_full & (data_fifo_depth <= DEPTH_THR).
  - Accepted byte with in_sof=1: write the byte, len=1, go to DATA. If in_eof is also set, handle it as in DATA.
  - Accepted byte with in_sof=0: drop it, err_cnt++, stay in IDLE.
- DATA:
  - in_ready=1. Each accepted byte is written, len++.
  - in_sof seen here is ignored (byte treated as data) and counts err_cnt++.
  - in_eof: go to PAD if len < MIN_LEN, otherwise to PTR.
  - len reaching MAX_LEN without eof: go to DISCARD, err_cnt++.
- PAD: in_ready=0. Write 0x00 one per cycle until len = MIN_LEN, then go to PTR.
- DISCARD: in_ready=1. Accepted bytes are dropped until in_eof, then go to PTR (len = MAX_LEN).
- PTR:
  - in_ready=0. Assert ptr_fifo_wr for exactly one cycle with {class, 1'b0, len}.
  - frame_cnt++; ptp_cnt++ if class is not 1. Return to IDLE.
- Latency:
  - data_fifo_wr/din is asserted the cycle after the input handshake.
  - The descriptor write is in the cycle after the last data/pad write, so it never precedes its data.
- Admission is checked only at sof. A frame in progress is never stalled by FIFO level; DEPTH_THR guarantees room for MAX_LEN.
- Width rules:
  - len is 11 bits and never exceeds MAX_LEN.
  - The byte offset counter saturates at 63 and is used for classification only.
  - Counters wrap at 16'hFFFF -> 0.
- Back-to-back: a new sof is accepted the cycle after PTR; minimum gap is one cycle.

Decomposition:
- Shared package mac_tx_pkg holds:
  - class codes CLS_SYNC/CLS_FOLLOW/CLS_REQ/CLS_NORMAL;
  - ethertypes 0x0800/0x88F7 and UDP ports 319/320;
  - PTP byte offsets;
  - the descriptor field layout;
  - the FSM state encoding.
- One sub-module: mac_t_ptp_classify. It takes the byte stream plus offset and outputs a registered class valid at eof.

Test Plan:
- 100-byte random frame, FIFOs empty -> 100 data writes, descriptor 16'h1064, frame_cnt=1.
- 86-byte UDPv4 PTP frame, byte 42=0x00, port 319 -> descriptor 16'h4056, ptp_cnt=1. Repeat with 0x08 -> 16'h8056, and with 0x01 -> 16'h0056.
- 40-byte frame -> 40 data bytes then 20 writes of 0x00, descriptor 16'h103C, in_ready=0 during PAD.
- 1600-byte frame -> exactly 1514 writes, descriptor 16'h15EA, 86 bytes consumed and dropped, err_cnt=1.
- data_fifo_depth=2579 or ptr_fifo_full=1 at sof -> in_ready=0, no writes. Release -> frame accepted unchanged.
- Reset asserted mid-frame after 30 bytes -> no descriptor, outputs 0. Next frame enqueues normally with correct len.
